alu_requester: RTL and testbench
================================

Name: alu_requester

Overview:
- Command-side master for the `alu` block.
- Accepts operation requests on a valid/ready port and drives `a`/`b`/`op_code` into the ALU.
- Waits out the ALU's registered latency, captures `{carry, result}`, and returns responses in order through a small response FIFO.
- Screens out illegal opcodes and divide-by-zero so the ALU is never issued an undefined operation.

Parameters:
- `DATA_W`, 8: operand and result width. The ALU output is `DATA_W+1` bits including carry.
- `TAG_W`, 4: width of the request tag echoed on the response.
- `RSP_DEPTH`, 4: response FIFO depth in entries (power of 2, ≥2).
- `ALU_LATENCY`, 1: cycles from the ALU sampling its inputs to its `result`/`carry` being valid (≥1).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_a` in `DATA_W`: operand A.
- `req_b` in `DATA_W`: operand B.
- `req_op` in 4: opcode. 0=add, 1=sub, 2=mul, 3=div.
- `req_tag` in `TAG_W`: caller tag.
- `alu_a` out `DATA_W`: drives ALU `a`.
- `alu_b` out `DATA_W`: drives ALU `b`.
- `alu_op` out 4: drives ALU `op_code`.
- `alu_result` in `DATA_W`: ALU `result`.
- `alu_carry` in 1: ALU `carry`.
- `rsp_valid` out 1: head FIFO entry valid.
- `rsp_ready` in 1: consumer pops on `rsp_valid && rsp_ready`.
- `rsp_result` out `DATA_W`: captured result.
- `rsp_carry` out 1: captured carry (bit `DATA_W` of the 9-bit ALU sum/diff/product).
- `rsp_err` out 1: request was rejected (illegal op or div by zero).
- `rsp_tag` out `TAG_W`: echoed tag.

Behaviour:
- **Reset** (`reset`=0 at a rising edge):
  - State returns to IDLE; FIFO is emptied (count=0, pointers=0).
  - `alu_a`/`alu_b`/`alu_op` = 0; `req_ready` = 0 during reset.
  - `rsp_valid` = 0; `rsp_result`/`rsp_carry`/`rsp_err`/`rsp_tag` = 0.
  - Any in-flight operation is discarded with no response.
- **`req_ready`**: `(state==IDLE) && (count < RSP_DEPTH)`. It is a registered-state decode and does not depend on `req_valid`.
- **FSM** (one operation in flight at a time):
  - IDLE: on accept, check the request.
    - If `req_op > 3`, or `req_op==3 && req_b==0`: go to ERR and do not touch the ALU inputs.
    - Otherwise: register `req_a`/`req_b`/`req_op` into `alu_a`/`alu_b`/`alu_op`, latch the tag, and go to ISSUE.
  - ISSUE: 1 cycle. The ALU samples at the end of this cycle. Next state is WAIT if `ALU_LATENCY>1`, else CAPTURE.
  - WAIT: `ALU_LATENCY-1` cycles, timed by a down-counter, then CAPTURE.
  - CAPTURE: 1 cycle. At its ending edge, push `{alu_result, alu_carry, err=0, tag}` into the FIFO, then return to IDLE.
  - ERR: 1 cycle. Push `{0, 0, err=1, tag}` into the FIFO, then return to IDLE.
- **ALU input hold**: `alu_a`/`alu_b`/`alu_op` hold their values from ISSUE through CAPTURE and retain the last values in IDLE.
- **Latency**, measured from the accept edge to `rsp_valid` high on an empty FIFO:
  - Legal op: `ALU_LATENCY+1` cycles (2 at the defaults).
  - Error op: 1 cycle.
- **Back-to-back**: the next accept can occur on the first IDLE cycle after CAPTURE/ERR. Sustained throughput is one legal op per `ALU_LATENCY+2` cycles.
- **FIFO**:
  - First-word-fall-through; outputs are registered from the head entry.
  - Push and pop on the same edge leave count unchanged.
  - Overflow cannot occur, because acceptance requires `count < RSP_DEPTH` and at most one push is in flight.
  - Pop when empty is ignored.
  - Read and write pointers wrap modulo `RSP_DEPTH`.
- **Ordering**: responses are strictly in acceptance order.
- **Pass-through**: no arithmetic is performed here. `rsp_result`/`rsp_carry` are taken unmodified from the ALU. Sub borrow appears as `carry`=1; mul is truncated to 9 bits.
- **Input stability**: requests arriving while `req_ready`=0 are ignored. `req_*` may change freely when not accepted.

Optional Feature:
- **`ALU_REQ_STATS_EN` defined**: adds two ports, `stat_issued` out 16 and `stat_err` out 16.
  - `stat_issued` increments on each CAPTURE push; `stat_err` increments on each ERR push.
  - Both saturate at 16'hFFFF and are cleared by reset.
- **Not defined**: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Add 200+100, tag 1 → `rsp_valid` 2 cycles after accept; result=44, carry=1, err=0, tag=1.
- Sub 5−7 → result=8'hFE, carry=1. Mul 16×16 → result=0, carry=1. Div 100/7 → result=14, carry=0.
- Div 9/0 and opcode 4'b0101 → `alu_*` unchanged; `rsp_valid` 1 cycle after accept; err=1, result=0, carry=0.
- Hold `rsp_ready`=0 and issue 5 legal requests (tags 0–4) → 4 accepted, `req_ready` stays 0 at count=4. Then set `rsp_ready`=1 → tags 0,1,2,3 drain in order, tag 4 is accepted next, and a same-cycle push/pop keeps count stable.
- Assert `reset`=0 during WAIT with `ALU_LATENCY`=3 → next cycle: IDLE, `rsp_valid`=0, `alu_*`=0, and no response is ever produced for the aborted tag.
- With `ALU_REQ_STATS_EN`: 3 legal + 2 error requests → `stat_issued`=3, `stat_err`=2; reset clears both to 0.

Source files
------------

// File: rtl/alu_requester.sv
// Command-side master for the alu block: screens requests, issues them, waits out the ALU latency and returns responses in order.
// Optional statistics ports stat_issued/stat_err are compiled in when ALU_REQ_STATS_EN is defined.
module alu_requester #(
    parameter int DATA_W      = 8,
    parameter int TAG_W       = 4,
    parameter int RSP_DEPTH   = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [3:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic [TAG_W-1:0]  rsp_tag
`ifdef ALU_REQ_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_err
`endif
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam int ENT_W = DATA_W + 2 + TAG_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt;
    logic [TAG_W-1:0]   tag_q;
    logic               accept;
    logic               req_bad;
    logic               push;
    logic               pop;
    logic [ENT_W-1:0]   push_data;

    logic [ENT_W-1:0]   mem [RSP_DEPTH];
    logic [PTR_W-1:0]   wptr, rptr, rptr_nxt;
    logic [PTR_W:0]     count, count_nxt;
    logic [ENT_W-1:0]   head_nxt;

    // Held low while reset is asserted so nothing is accepted during reset.
    assign req_ready = reset && (state == S_IDLE) && (count < (PTR_W+1)'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign req_bad   = (req_op > 4'd3) || ((req_op == 4'd3) && (req_b == '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = req_bad ? S_ERR : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = (ALU_LATENCY > 1) ? S_WAIT : S_CAPTURE;
            end
            S_WAIT: begin
                if (wait_cnt == CNT_W'(1)) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                push      = 1'b1;
                push_data = {alu_result, alu_carry, 1'b0, tag_q};
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                push      = 1'b1;
                push_data = {{DATA_W{1'b0}}, 1'b0, 1'b1, tag_q};
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Issue stage: operands are only loaded for legal requests and then held until the next one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tag_q    <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                tag_q <= req_tag;
                if (!req_bad) begin
                    alu_a  <= req_a;
                    alu_b  <= req_b;
                    alu_op <= req_op;
                end
            end
            if (state == S_ISSUE) begin
                wait_cnt <= CNT_W'(ALU_LATENCY - 1);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
        end
    end

    // Response FIFO: the output register is loaded with whatever will be at the head after this edge.
    assign pop      = rsp_valid && rsp_ready;
    assign rptr_nxt = pop ? (rptr + PTR_W'(1)) : rptr;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + (PTR_W+1)'(1);
        end else if (!push && pop) begin
            count_nxt = count - (PTR_W+1)'(1);
        end
        head_nxt = (push && (wptr == rptr_nxt)) ? push_data : mem[rptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_tag    <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            rptr      <= rptr_nxt;
            count     <= count_nxt;
            rsp_valid <= (count_nxt != '0);
            {rsp_result, rsp_carry, rsp_err, rsp_tag} <= (count_nxt != '0) ? head_nxt : '0;
        end
    end

`ifdef ALU_REQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_issued <= '0;
            stat_err    <= '0;
        end else begin
            if (state == S_CAPTURE) begin
                stat_issued <= sat_inc(stat_issued);
            end
            if (state == S_ERR) begin
                stat_err <= sat_inc(stat_err);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_requester.sv
// Self-checking bench for alu_requester: directed cases, FIFO-full, randomized traffic against a queue model, and an abort on a 3-cycle ALU.
module tb_alu_requester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready;
    logic [7:0]  req_a, req_b;
    logic [3:0]  req_op, req_tag;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_carry;
    logic        rsp_valid, rsp_ready, rsp_carry, rsp_err;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_tag;

    logic        reset3;
    logic        r3_valid, r3_ready;
    logic [7:0]  r3_a, r3_b;
    logic [3:0]  r3_op, r3_tag;
    logic [7:0]  a3_a, a3_b, a3_res;
    logic [3:0]  a3_op;
    logic        a3_carry;
    logic        s3_valid, s3_ready, s3_carry, s3_err;
    logic [7:0]  s3_result;
    logic [3:0]  s3_tag;

`ifdef ALU_REQ_STATS_EN
    logic [15:0] stat_issued, stat_err, stat3_issued, stat3_err;
`endif

    alu_requester #(.DATA_W(8), .TAG_W(4), .RSP_DEPTH(4), .ALU_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag)
`ifdef ALU_REQ_STATS_EN
        , .stat_issued(stat_issued), .stat_err(stat_err)
`endif
    );

    alu_requester #(.DATA_W(8), .TAG_W(4), .RSP_DEPTH(4), .ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset3),
        .req_valid(r3_valid), .req_ready(r3_ready),
        .req_a(r3_a), .req_b(r3_b), .req_op(r3_op), .req_tag(r3_tag),
        .alu_a(a3_a), .alu_b(a3_b), .alu_op(a3_op),
        .alu_result(a3_res), .alu_carry(a3_carry),
        .rsp_valid(s3_valid), .rsp_ready(s3_ready),
        .rsp_result(s3_result), .rsp_carry(s3_carry), .rsp_err(s3_err), .rsp_tag(s3_tag)
`ifdef ALU_REQ_STATS_EN
        , .stat_issued(stat3_issued), .stat_err(stat3_err)
`endif
    );

    // Behavioural ALU stand-ins with 1 and 3 cycles of registered latency.
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [17:0] p;
        p = a * b;
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return p[8:0];
            4'd3:    return (b == 8'd0) ? 9'd0 : {1'b0, a / b};
            default: return 9'd0;
        endcase
    endfunction

    logic [8:0] alu_q;
    logic [8:0] p3 [3];
    always @(posedge clk) begin
        alu_q <= alu_fn(alu_op, alu_a, alu_b);
        p3[0] <= alu_fn(a3_op, a3_a, a3_b);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign alu_result = alu_q[7:0];
    assign alu_carry  = alu_q[8];
    assign a3_res     = p3[2][7:0];
    assign a3_carry   = p3[2][8];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference: response fields {result[7:0], carry, err, tag[3:0]} from plain integer arithmetic.
    function automatic logic [13:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] tag);
        int unsigned x, y, r;
        x = a;
        y = b;
        if (op > 4'd3 || (op == 4'd3 && y == 0)) return {8'd0, 1'b0, 1'b1, tag};
        case (op)
            4'd0:    r = x + y;
            4'd1:    r = x - y;
            4'd2:    r = x * y;
            default: r = x / y;
        endcase
        return {r[7:0], r[8], 1'b0, tag};
    endfunction

    logic [13:0] exp_q[$];
    logic [13:0] mon_e;
    logic        mon_have;
    int          n_leg = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (rsp_valid && rsp_ready) begin
                mon_have = (exp_q.size() != 0);
                mon_e    = mon_have ? exp_q.pop_front() : 14'd0;
                check("rsp_order", 32'({1'b1, rsp_result, rsp_carry, rsp_err, rsp_tag}), 32'({mon_have, mon_e}));
            end
            if (req_valid && req_ready) begin
                mon_e = model(req_op, req_a, req_b, req_tag);
                exp_q.push_back(mon_e);
                if (mon_e[4]) n_bad++;
                else n_leg++;
            end
        end
    end

    bit watch3 = 1'b0;
    bit seen3  = 1'b0;
    always @(negedge clk) begin
        if (!watch3) seen3 = 1'b0;
        else if (s3_valid) seen3 = 1'b1;
    end

    task automatic do_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("req_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin lat = i; break; end
        end
    endtask

    task automatic dir_op(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] tag, input int exp_lat, input logic [13:0] exp_f);
        int lat;
        do_req(op, a, b, tag);
        wait_rsp(lat);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_val"}, 32'({rsp_result, rsp_carry, rsp_err, rsp_tag}), 32'(exp_f));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat3, streak;
        bit hi_seen, acc;
        reset = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0; rsp_ready = 1'b0;
        reset3 = 1'b0; r3_valid = 1'b0; r3_a = '0; r3_b = '0; r3_op = '0; r3_tag = '0; s3_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("rst_rsp", 32'({rsp_result, rsp_carry, rsp_err, rsp_tag}), 32'd0);
        reset = 1'b1; mon_en = 1'b1; rsp_ready = 1'b1;

        dir_op("add",   4'd0, 8'd200, 8'd100, 4'd1, 2, {8'd44,  1'b1, 1'b0, 4'd1});
        dir_op("sub",   4'd1, 8'd5,   8'd7,   4'd2, 2, {8'hFE,  1'b1, 1'b0, 4'd2});
        dir_op("mul",   4'd2, 8'd16,  8'd16,  4'd3, 2, {8'd0,   1'b1, 1'b0, 4'd3});
        dir_op("div",   4'd3, 8'd100, 8'd7,   4'd4, 2, {8'd14,  1'b0, 1'b0, 4'd4});
        dir_op("div0",  4'd3, 8'd9,   8'd0,   4'd5, 1, {8'd0,   1'b0, 1'b1, 4'd5});
        check("div0_alu_hold", 32'({alu_a, alu_b, alu_op}), 32'({8'd100, 8'd7, 4'd3}));
        dir_op("badop", 4'b0101, 8'd1, 8'd2,  4'd6, 1, {8'd0,   1'b0, 1'b1, 4'd6});
        check("badop_alu_hold", 32'({alu_a, alu_b, alu_op}), 32'({8'd100, 8'd7, 4'd3}));

        // Fill the FIFO with the consumer stalled, then release it.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) do_req(4'd0, 8'($urandom), 8'($urandom), 4'(t));
        repeat (3) @(posedge clk);
        #1;
        req_op = 4'd1; req_a = 8'd9; req_b = 8'd3; req_tag = 4'd4; req_valid = 1'b1;
        hi_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_ready) hi_seen = 1'b1;
        end
        check("full_req_ready", 32'(hi_seen), 32'd0);
        check("full_head", 32'({rsp_valid, rsp_tag}), 32'({1'b1, 4'd0}));
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        streak = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) streak++;
            else if (streak > 0) break;
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) req_valid = 1'b0;
        end
        check("drain_streak", 32'(streak), 32'd5);

        // Randomized traffic with a randomly stalling consumer.
        begin
            bit rnd_done;
            rnd_done = 1'b0;
            fork
                begin
                    logic [3:0] op;
                    logic [7:0] b;
                    for (int i = 0; i < 60; i++) begin
                        op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                        b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
                        do_req(op, 8'($urandom), b, 4'(i));
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        @(posedge clk); #1;
                        rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            join
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) break;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_rsp_valid", 32'(rsp_valid), 32'd0);

`ifdef ALU_REQ_STATS_EN
        check("stat_issued", 32'(stat_issued), 32'(n_leg));
        check("stat_err", 32'(stat_err), 32'(n_bad));
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst2_req_ready", 32'(req_ready), 32'd0);
        check("rst2_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
`ifdef ALU_REQ_STATS_EN
        check("rst2_stats", 32'({stat_issued, stat_err}), 32'd0);
`endif
        reset = 1'b1;

        // Three-cycle ALU: latency, then reset while waiting.
        reset3 = 1'b1;
        r3_op = 4'd0; r3_a = 8'd3; r3_b = 8'd4; r3_tag = 4'd2; r3_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r3_ready) break;
        end
        @(posedge clk); #1;
        r3_valid = 1'b0;
        lat3 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (s3_valid) begin lat3 = i; break; end
        end
        check("lat3_latency", 32'(lat3), 32'd4);
        check("lat3_val", 32'({s3_result, s3_carry, s3_err, s3_tag}), 32'({8'd7, 1'b0, 1'b0, 4'd2}));

        @(posedge clk); #1;
        r3_op = 4'd2; r3_a = 8'd10; r3_b = 8'd20; r3_tag = 4'd9; r3_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r3_ready) break;
        end
        @(posedge clk); #1;
        r3_valid = 1'b0;
        @(posedge clk); #1;
        reset3 = 1'b0;
        @(posedge clk); #1;
        check("abort_rsp_valid", 32'(s3_valid), 32'd0);
        check("abort_alu", 32'({a3_a, a3_b, a3_op}), 32'd0);
        check("abort_ready_in_reset", 32'(r3_ready), 32'd0);
        reset3 = 1'b1;
        #1;
        check("abort_idle", 32'(r3_ready), 32'd1);
        watch3 = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_rsp", 32'(seen3), 32'd0);
        watch3 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
